// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side agents.
//   - rd_state_e   : read streamer control state (2-bit encoding)
//   - FifoWidth    : default data word width, shared with the FIFO and its bench
//   - FifoLenWidth : default transfer-length width
//   - StatCntWidth : default statistics counter width
package fifo_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } rd_state_e;

    localparam int unsigned FifoWidth    = 8;
    localparam int unsigned FifoLenWidth = 10;
    localparam int unsigned StatCntWidth = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer with valid/ready handshake on the read side.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i        : write push_data_i into the tail (caller guarantees space)
//   push_data_i   : word to store
//   ready_i       : sink ready; the head is popped when valid_o && ready_i
//   valid_o       : buffer holds at least one word
//   data_o        : head word, held stable until popped
//   count_o       : number of words held (0..2)
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FifoWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             pop;

    assign valid_o = (count_q != 2'd0);
    assign pop     = valid_o && ready_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Push and pop in the same cycle leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side agent for the synchronous FIFO: drains len_i words from the FIFO
// read port and presents them on a valid/ready stream with a last marker.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i, len_i      : start a transfer of len_i words (accepted in IDLE only)
//   abort_i             : stop issuing reads (RUN only); buffered words still drain
//   rd_en_o, rdata_i    : FIFO read port, data valid the cycle after rd_en_o
//   empty_i, fifo_err_i : FIFO status
//   m_valid_o, m_data_o, m_last_o, m_ready_i : output stream
//   busy_o, done_o, err_o, xfer_cnt_o        : status and statistics
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FifoWidth,
    parameter int unsigned LEN_WIDTH = FifoLenWidth,
    parameter int unsigned CNT_WIDTH = StatCntWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic                 abort_i,
    output logic                 rd_en_o,
    input  logic [WIDTH-1:0]     rdata_i,
    input  logic                 empty_i,
    input  logic                 fifo_err_i,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_last_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o
);

    rd_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_req_q, rem_req_d;
    logic [LEN_WIDTH-1:0] rem_out_q, rem_out_d;
    logic                 inflight_q;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [1:0]           buf_count;
    logic                 handshake;
    logic                 credit_ok;

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i (rdata_i),
        .ready_i     (m_ready_i),
        .valid_o     (m_valid_o),
        .data_o      (m_data_o),
        .count_o     (buf_count)
    );

    assign handshake = m_valid_o && m_ready_i;

    // Buffered plus in-flight words must stay below 2; a word leaving the
    // buffer this cycle frees its slot, which sustains one read per cycle.
    assign credit_ok = ({1'b0, buf_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, handshake});

    assign rd_en_o = (state_q == StRun) && (rem_req_q != '0) && !empty_i && credit_ok && !abort_i;

    // After an abort the final delivered word is the only one left in the pipe.
    assign m_last_o = m_valid_o &&
                      ((rem_out_q == LEN_WIDTH'(1)) ||
                       ((state_q == StFlush) && (buf_count == 2'd1) && !inflight_q));

    assign busy_o     = (state_q == StRun) || (state_q == StFlush);
    assign done_o     = (state_q == StDone);
    assign err_o      = err_q;
    assign xfer_cnt_o = xfer_cnt_q;

    always_comb begin
        state_d    = state_q;
        rem_req_d  = rem_req_q;
        rem_out_d  = rem_out_q;
        err_d      = err_q;
        xfer_cnt_d = xfer_cnt_q;

        if (handshake) begin
            rem_out_d  = rem_out_q - LEN_WIDTH'(1);
            xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
        end
        if ((state_q != StIdle) && fifo_err_i) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        rem_req_d = len_i;
                        rem_out_d = len_i;
                        state_d   = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (rd_en_o) begin
                    rem_req_d = rem_req_q - LEN_WIDTH'(1);
                end
                if ((rem_req_d == '0) || abort_i) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!inflight_q && (buf_count == 2'd0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            rem_req_q  <= '0;
            rem_out_q  <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_req_q  <= rem_req_d;
            rem_out_q  <= rem_out_d;
            inflight_q <= rd_en_o;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;

    localparam int W  = 8;
    localparam int LW = 10;
    localparam int CW = 16;

    localparam int PhIdle  = 0;
    localparam int PhRun   = 1;
    localparam int PhFlush = 2;
    localparam int PhDone  = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic          abort_i = 1'b0;
    logic          rd_en_o;
    logic [W-1:0]  rdata_i = '0;
    logic          empty_i = 1'b1;
    logic          fifo_err_i = 1'b0;
    logic          m_valid_o;
    logic [W-1:0]  m_data_o;
    logic          m_last_o;
    logic          m_ready_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [CW-1:0] xfer_cnt_o;

    fifo_rd_streamer #(
        .WIDTH     (W),
        .LEN_WIDTH (LW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .abort_i    (abort_i),
        .rd_en_o    (rd_en_o),
        .rdata_i    (rdata_i),
        .empty_i    (empty_i),
        .fifo_err_i (fifo_err_i),
        .m_valid_o  (m_valid_o),
        .m_data_o   (m_data_o),
        .m_last_o   (m_last_o),
        .m_ready_i  (m_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .xfer_cnt_o (xfer_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, words read but not yet delivered, and
    // transfer bookkeeping in plain counts.
    logic [W-1:0] fifo_q [$];
    logic [W-1:0] obuf [$];
    bit           infl;
    logic [W-1:0] infl_word;
    int           ph;
    int           req_left;
    int           out_left;
    bit           merr;
    int           xcnt;

    // Stimulus knobs
    int rdy_mode  = 0;   // 0 constant, 1 pattern 1,0,0,1, 2 random
    bit rdy_const = 1'b1;
    bit rand_push = 1'b0;
    int pat_i     = 0;

    // Observation logs of the DUT for hand-computed checks
    logic [W-1:0] got [$];
    int n_rd, cur_run, max_run, n_last, last_pos, n_done;
    bit busy_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_logs();
        got.delete();
        n_rd = 0; cur_run = 0; max_run = 0; n_last = 0; last_pos = 0; n_done = 0;
        busy_seen = 1'b0;
    endtask

    task automatic model_reset();
        obuf.delete();
        infl = 1'b0; ph = PhIdle; req_left = 0; out_left = 0; merr = 1'b0; xcnt = 0;
    endtask

    // One clock cycle, negedge to negedge: settle inputs, compare every
    // output against the model, then advance the model past the posedge.
    task automatic cycle();
        bit exp_valid, hs, exp_rd, exp_last, pipe_empty;
        int occ;
        case (rdy_mode)
            0:       m_ready_i = rdy_const;
            1:       m_ready_i = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
            default: m_ready_i = ($urandom_range(0, 3) != 0);
        endcase
        pat_i++;
        if (rand_push && fifo_q.size() < 32 && $urandom_range(0, 2) == 0)
            fifo_q.push_back(W'($urandom));
        empty_i = (fifo_q.size() == 0);
        #1;
        exp_valid = (obuf.size() != 0);
        hs        = exp_valid && m_ready_i;
        occ       = obuf.size() + int'(infl) - int'(hs);
        exp_rd    = (ph == PhRun) && (req_left > 0) && (fifo_q.size() > 0) && !abort_i && (occ < 2);
        exp_last  = exp_valid && ((out_left == 1) ||
                    ((ph == PhFlush) && (obuf.size() == 1) && !infl));
        chk("rd_en", rd_en_o, exp_rd);
        chk("m_valid", m_valid_o, exp_valid);
        if (exp_valid) chk("m_data", m_data_o, obuf[0]);
        chk("m_last", m_last_o, exp_last);
        chk("busy", busy_o, (ph == PhRun) || (ph == PhFlush));
        chk("done", done_o, ph == PhDone);
        chk("err", err_o, merr);
        chk("xfer_cnt", xfer_cnt_o, xcnt);

        if (rd_en_o) begin
            n_rd++; cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (m_valid_o && m_ready_i) begin
            got.push_back(m_data_o);
            if (m_last_o) begin n_last++; last_pos = got.size(); end
        end
        if (done_o) n_done++;
        if (busy_o) busy_seen = 1'b1;

        pipe_empty = (obuf.size() == 0) && !infl;
        if (hs) begin
            void'(obuf.pop_front());
            out_left--;
            xcnt = (xcnt + 1) % (1 << CW);
        end
        if (infl) obuf.push_back(infl_word);
        infl = exp_rd;
        if (exp_rd) infl_word = fifo_q.pop_front();
        if (ph != PhIdle && fifo_err_i) merr = 1'b1;
        case (ph)
            PhIdle: if (start_i) begin
                merr = 1'b0;
                if (len_i != 0) begin
                    req_left = len_i; out_left = len_i; ph = PhRun;
                end else begin
                    ph = PhDone;
                end
            end
            PhRun: begin
                if (exp_rd) req_left--;
                if (req_left == 0 || abort_i) ph = PhFlush;
            end
            PhFlush: if (pipe_empty) ph = PhDone;
            default: ph = PhIdle;
        endcase

        @(negedge clk_i);
        if (infl) rdata_i = infl_word;
    endtask

    task automatic start(input int len);
        start_i = 1'b1;
        len_i   = LW'(len);
        cycle();
        start_i = 1'b0;
    endtask

    task automatic run_idle(input int budget, input string nm);
        int n = 0;
        while (ph != PhIdle && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (ph != PhIdle) begin
            errors++;
            $display("FAIL %s_timeout: still active after %0d cycles", nm, budget);
        end
    endtask

    task automatic check_seq(input string nm, input int base, input int n);
        chk({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk({nm, "_word"}, got[i], (base + i) & 8'hFF);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_rd_en"}, rd_en_o, 0);
        chk({nm, "_m_valid"}, m_valid_o, 0);
        chk({nm, "_m_data"}, m_data_o, 0);
        chk({nm, "_m_last"}, m_last_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_done"}, done_o, 0);
        chk({nm, "_err"}, err_o, 0);
        chk({nm, "_xfer_cnt"}, xfer_cnt_o, 0);
    endtask

    initial begin
        int n;
        model_reset();
        clear_logs();
        #3;
        check_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Full-rate drain of 16 words
        for (int i = 0; i < 16; i++) fifo_q.push_back(W'(8'h11 + i));
        clear_logs();
        rdy_mode = 0; rdy_const = 1'b1;
        start(16);
        run_idle(60, "t1");
        check_seq("t1", 8'h11, 16);
        chk("t1_max_rd_run", max_run, 16);
        chk("t1_n_last", n_last, 1);
        chk("t1_last_pos", last_pos, 16);
        chk("t1_n_done", n_done, 1);
        chk("t1_xfer_cnt", xfer_cnt_o, 16);

        // Same drain with sink pattern 1,0,0,1
        for (int i = 0; i < 16; i++) fifo_q.push_back(W'(8'h11 + i));
        clear_logs();
        rdy_mode = 1; pat_i = 0;
        start(16);
        run_idle(120, "t2");
        check_seq("t2", 8'h11, 16);
        chk("t2_n_last", n_last, 1);
        chk("t2_last_pos", last_pos, 16);
        chk("t2_xfer_cnt", xfer_cnt_o, 32);

        // FIFO runs dry mid-transfer, then refills
        for (int i = 0; i < 3; i++) fifo_q.push_back(W'(8'hA1 + i));
        clear_logs();
        rdy_mode = 0; rdy_const = 1'b1;
        start(5);
        repeat (10) cycle();
        #1;
        chk("t3_stall_busy", busy_o, 1);
        chk("t3_stall_rd_en", rd_en_o, 0);
        chk("t3_stall_count", got.size(), 3);
        fifo_q.push_back(8'hA4);
        fifo_q.push_back(8'hA5);
        run_idle(40, "t3");
        check_seq("t3", 8'hA1, 5);
        chk("t3_last_pos", last_pos, 5);
        chk("t3_n_done", n_done, 1);

        // Abort after the fourth read
        for (int i = 0; i < 8; i++) fifo_q.push_back(W'(8'h31 + i));
        clear_logs();
        start(8);
        n = 0;
        while (n_rd < 4 && n < 20) begin cycle(); n++; end
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        run_idle(40, "t4");
        check_seq("t4", 8'h31, 4);
        chk("t4_n_last", n_last, 1);
        chk("t4_last_pos", last_pos, 4);
        chk("t4_fifo_left", fifo_q.size(), 4);
        chk("t4_n_done", n_done, 1);
        fifo_q.delete();
        repeat (2) cycle();

        // Zero-length start
        clear_logs();
        start(0);
        chk("t5_done_next", done_o, 1);
        run_idle(10, "t5");
        chk("t5_n_done", n_done, 1);
        chk("t5_n_rd", n_rd, 0);
        chk("t5_busy_seen", busy_seen, 0);

        // Sticky error
        for (int i = 0; i < 4; i++) fifo_q.push_back(W'(8'h51 + i));
        clear_logs();
        start(4);
        cycle();
        fifo_err_i = 1'b1;
        cycle();
        fifo_err_i = 1'b0;
        run_idle(40, "t5e");
        check_seq("t5e", 8'h51, 4);
        repeat (3) cycle();
        #1;
        chk("t5e_err_sticky", err_o, 1);
        start(0);
        #1;
        chk("t5e_err_cleared", err_o, 0);
        run_idle(10, "t5z");

        // Asynchronous reset with two words buffered
        for (int i = 0; i < 8; i++) fifo_q.push_back(W'(8'h41 + i));
        clear_logs();
        rdy_const = 1'b0;
        start(8);
        n = 0;
        while (obuf.size() < 2 && n < 10) begin cycle(); n++; end
        chk("t6_buffered", obuf.size(), 2);
        #2;
        rst_i = 1'b1;
        #1;
        check_zero("t6_reset");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_logs();
        rdy_const = 1'b1;
        start(4);
        run_idle(40, "t6");
        check_seq("t6", 8'h43, 4);
        chk("t6_last_pos", last_pos, 4);
        chk("t6_xfer_cnt", xfer_cnt_o, 4);
        fifo_q.delete();
        repeat (2) cycle();

        // Randomized transfers against the model
        rdy_mode = 2; rand_push = 1'b1;
        for (int t = 0; t < 10; t++) begin
            int len;
            len = $urandom_range(1, 12);
            repeat ($urandom_range(0, len)) fifo_q.push_back(W'($urandom));
            start(len);
            n = 0;
            while (ph != PhIdle && n < 400) begin
                abort_i    = ($urandom_range(0, 39) == 0);
                fifo_err_i = ($urandom_range(0, 49) == 0);
                start_i    = ($urandom_range(0, 19) == 0);
                len_i      = LW'($urandom_range(0, 15));
                cycle();
                n++;
            end
            abort_i = 1'b0; fifo_err_i = 1'b0; start_i = 1'b0;
            checks++;
            if (ph != PhIdle) begin
                errors++;
                $display("FAIL rand_timeout: transfer %0d still active", t);
            end
            repeat (2) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
